// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, followed by a sign-fix cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_start,
    input  logic [1:0]       sig_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             sig_mt_hi,
    input  logic             sig_mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             sig_busy,
    output logic             sig_done,
    output logic             sig_div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} stateType;

    stateType           state;
    logic [CW-1:0]      counter;
    logic               isDiv, negRes, negRem, divZero;
    logic [WIDTH-1:0]   operand, origA;
    logic [2*WIDTH-1:0] acc;

    logic               isSigned, signA, signB;
    logic [WIDTH-1:0]   magA, magB;

    assign sig_busy = (state != IDLE);
    assign isSigned = ~sig_op[0];
    assign signA    = isSigned & src_a[WIDTH-1];
    assign signB    = isSigned & src_b[WIDTH-1];
    assign magA     = signA ? -src_a : src_a;
    assign magB     = signB ? -src_b : src_b;

    // acc holds {partial product, multiplier} for mult, {remainder, quotient} for div
    logic [WIDTH:0]     addSum, subDiff;
    logic [2*WIDTH-1:0] accNext;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        accNext = acc;
        addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        subDiff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (isDiv) begin
            if (!subDiff[WIDTH])
                accNext = {subDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                accNext = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                accNext = {addSum, acc[WIDTH-1:1]};
            else
                accNext = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder;

    assign product   = negRes ? -acc : acc;
    assign quotient  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remainder = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= IDLE;
            counter      <= '0;
            hi           <= '0;
            lo           <= '0;
            sig_done     <= 1'b0;
            sig_div_zero <= 1'b0;
        end else begin
            sig_done     <= 1'b0;
            sig_div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (sig_start) begin
                        isDiv   <= sig_op[1];
                        negRes  <= signA ^ signB;
                        negRem  <= signA;
                        divZero <= sig_op[1] & (src_b == '0);
                        origA   <= src_a;
                        operand <= sig_op[1] ? magB : magA;
                        acc     <= {{WIDTH{1'b0}}, (sig_op[1] ? magA : magB)};
                        counter <= '0;
                        state   <= RUN;
                    end else begin
                        if (sig_mt_hi) hi <= mt_data;
                        if (sig_mt_lo) lo <= mt_data;
                    end
                end
                RUN: begin
                    acc     <= accNext;
                    counter <= counter + 1'b1;
                    if (counter == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (!isDiv) begin
                        hi <= product[2*WIDTH-1:WIDTH];
                        lo <= product[WIDTH-1:0];
                    end else if (divZero) begin
                        hi <= origA;
                        lo <= '1;
                    end else begin
                        hi <= remainder;
                        lo <= quotient;
                    end
                    sig_done     <= 1'b1;
                    sig_div_zero <= divZero;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
